// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: period (rise to rise) and high time in clock cycles,
// with a timeout report when no rising edge arrives within MAX clocks.
module pwm_capture #(
    parameter int RESOLUTION  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_pwm,
    output logic [RESOLUTION+1:0] o_period,
    output logic [RESOLUTION+1:0] o_high,
    output logic                  o_valid,
    output logic                  o_timeout,
    output logic                  o_level
);
    localparam int            CW    = RESOLUTION + 2;
    localparam logic [CW-1:0] MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO  = {CW{1'b0}};

    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_MEAS = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          r_high;
    logic [CW-1:0]          w_cnt_nxt;
    logic [CW-1:0]          w_high_nxt;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_report;
    logic                   w_timeout;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_prev;

    // Input synchronizer, edge-detect history, FSM state and counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync  <= {SYNC_STAGES{1'b0}};
            r_prev  <= 1'b0;
            r_state <= S_WAIT;
            r_cnt   <= ZERO;
            r_high  <= ZERO;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pwm};
            r_prev  <= w_s;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_high  <= w_high_nxt;
        end
    end

    // Next-state, counter updates and report decision; a rise always beats the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + ONE;
        w_high_nxt  = r_high;
        w_report    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_rise) begin
                    w_cnt_nxt   = ONE;
                    w_high_nxt  = ONE;
                    w_state_nxt = S_MEAS;
                end else if (r_cnt == MAX) begin
                    w_report  = 1'b1;
                    w_timeout = 1'b1;
                    w_cnt_nxt = ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            S_MEAS: begin
                if (w_rise) begin
                    w_report   = 1'b1;
                    w_cnt_nxt  = ONE;
                    w_high_nxt = ONE;
                end else if (r_cnt == MAX) begin
                    w_report    = 1'b1;
                    w_timeout   = 1'b1;
                    w_cnt_nxt   = ZERO;
                    w_high_nxt  = ZERO;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt  = r_cnt + ONE;
                    w_high_nxt = r_high + {{(CW-1){1'b0}}, w_s};
                end
            end
            default: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = ZERO;
                w_high_nxt  = ZERO;
            end
        endcase
    end

    // Registered report outputs; data fields hold between strobes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_period  <= ZERO;
            o_high    <= ZERO;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            o_level   <= 1'b0;
        end else begin
            o_valid <= w_report;
            if (w_report) begin
                o_period  <= w_timeout ? ZERO : r_cnt;
                o_high    <= w_timeout ? ZERO : r_high;
                o_timeout <= w_timeout;
                o_level   <= w_s;
            end else begin
                o_period  <= o_period;
                o_high    <= o_high;
                o_timeout <= o_timeout;
                o_level   <= o_level;
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: drives PWM waveforms as level/duration segments and
// predicts every report (values and arrival cycle) from rise-to-rise timing.
module tb_pwm_capture;
    localparam int CW  = 10;
    localparam int MAX = 1023;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm = 1'b0;
    logic [CW-1:0] o_period;
    logic [CW-1:0] o_high;
    logic          o_valid;
    logic          o_timeout;
    logic          o_level;

    pwm_capture #(.RESOLUTION(8), .SYNC_STAGES(2)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_pwm    (pwm),
        .o_period (o_period),
        .o_high   (o_high),
        .o_valid  (o_valid),
        .o_timeout(o_timeout),
        .o_level  (o_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0] period;
        logic [CW-1:0] high;
        logic          timeout;
        logic          level;
        int            cyc;
    } rep_t;

    rep_t obs[$];
    rep_t exp_q[$];
    int   plan_p[$];
    int   plan_h[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always @(posedge clk) begin
        rep_t r;
        #1;
        if (o_valid === 1'b1) begin
            r.period  = o_period;
            r.high    = o_high;
            r.timeout = o_timeout;
            r.level   = o_level;
            r.cyc     = cyc;
            obs.push_back(r);
        end
    end

    task automatic drive_level(input logic v, input int n, output int t);
        @(posedge clk);
        #1;
        pwm = v;
        t   = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic apply_reset(input logic v, output int rel);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pwm = v;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rel = cyc;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic push_exp(input int p, input int h, input logic to, input logic lv, input int c);
        rep_t r;
        r.period  = CW'(p);
        r.high    = CW'(h);
        r.timeout = to;
        r.level   = lv;
        r.cyc     = c;
        exp_q.push_back(r);
    endtask

    // Plays the planned periods after a lead-in low; each rise closes the previous period.
    task automatic run_plan();
        int t;
        int t2;
        int rises[$];
        drive_level(1'b0, 5, t);
        for (int i = 0; i < plan_p.size(); i++) begin
            drive_level(1'b1, plan_h[i], t);
            rises.push_back(t);
            drive_level(1'b0, plan_p[i] - plan_h[i], t2);
        end
        drive_level(1'b1, 1, t);
        rises.push_back(t);
        drive_level(1'b0, 8, t2);
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < plan_p.size(); i++)
            push_exp(plan_p[i], plan_h[i], 1'b0, 1'b1, rises[i+1] + LAT);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pwm = 1'($urandom_range(1, 0));
        repeat (4) @(posedge clk);
        #1;
        n_cmp += 5;
        if (o_period !== 10'd0) begin n_fail++; $display("FAIL reset_period got %0d want 0", o_period); end
        if (o_high !== 10'd0) begin n_fail++; $display("FAIL reset_high got %0d want 0", o_high); end
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
        if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", o_timeout); end
        if (o_level !== 1'b0) begin n_fail++; $display("FAIL reset_level got %b want 0", o_level); end
    endtask

    task automatic test_pulse_train(input string name);
        int rel;
        apply_reset(1'b0, rel);
        run_plan();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s count got %0d want %0d", name, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i].period !== exp_q[i].period || obs[i].high !== exp_q[i].high ||
                obs[i].timeout !== exp_q[i].timeout || obs[i].level !== exp_q[i].level ||
                obs[i].cyc != exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL %s[%0d] got p=%0d h=%0d to=%b lv=%b cyc=%0d want p=%0d h=%0d to=%b lv=%b cyc=%0d",
                         name, i, obs[i].period, obs[i].high, obs[i].timeout, obs[i].level, obs[i].cyc,
                         exp_q[i].period, exp_q[i].high, exp_q[i].timeout, exp_q[i].level, exp_q[i].cyc);
            end
        end
        plan_p.delete();
        plan_h.delete();
    endtask

    // Constant input: first report MAX+1 clocks after the counter starts, then every MAX+1.
    task automatic test_timeout(input logic lv);
        int rel;
        int first;
        apply_reset(lv, rel);
        first = lv ? rel + LAT + MAX : rel + MAX + 1;
        repeat (2100) @(posedge clk);
        #2;
        push_exp(0, 0, 1'b1, lv, first);
        push_exp(0, 0, 1'b1, lv, first + MAX + 1);
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL timeout_lv%0b count got %0d want %0d", lv, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i].period !== exp_q[i].period || obs[i].high !== exp_q[i].high ||
                obs[i].timeout !== exp_q[i].timeout || obs[i].level !== exp_q[i].level ||
                obs[i].cyc != exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL timeout_lv%0b[%0d] got p=%0d h=%0d to=%b lv=%b cyc=%0d want to=1 lv=%b cyc=%0d",
                         lv, i, obs[i].period, obs[i].high, obs[i].timeout, obs[i].level, obs[i].cyc,
                         exp_q[i].level, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rel;
        int t;
        apply_reset(1'b0, rel);
        drive_level(1'b0, 5, t);
        drive_level(1'b1, 64, t);
        drive_level(1'b0, 192, t);
        drive_level(1'b1, 64, t);
        drive_level(1'b0, 100, t);
        #2;
        n_cmp++;
        if (o_period !== 10'd256 || o_high !== 10'd64) begin
            n_fail++;
            $display("FAIL pre_reset got p=%0d h=%0d want p=256 h=64", o_period, o_high);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({o_period, o_high, o_valid, o_timeout, o_level} !== 23'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got p=%0d h=%0d v=%b to=%b lv=%b want all 0",
                     o_period, o_high, o_valid, o_timeout, o_level);
        end
        rst = 1'b0;
        obs.delete();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            plan_p.push_back(int'($urandom_range(200, 2)));
            plan_h.push_back(int'($urandom_range(plan_p[i] - 1, 1)));
        end
        run_plan();
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL reset_mid count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs[i].period !== exp_q[i].period || obs[i].high !== exp_q[i].high ||
                obs[i].timeout !== exp_q[i].timeout || obs[i].cyc != exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL reset_mid[%0d] got p=%0d h=%0d to=%b cyc=%0d want p=%0d h=%0d to=0 cyc=%0d",
                         i, obs[i].period, obs[i].high, obs[i].timeout, obs[i].cyc,
                         exp_q[i].period, exp_q[i].high, exp_q[i].cyc);
            end
        end
        plan_p.delete();
        plan_h.delete();
    endtask

    initial begin
        int p;
        test_reset();

        repeat (4) begin plan_p.push_back(256); plan_h.push_back(64); end
        test_pulse_train("p256_h64");

        repeat (8) begin plan_p.push_back(2); plan_h.push_back(1); end
        test_pulse_train("p2_h1");

        repeat (2) begin plan_p.push_back(100); plan_h.push_back(30); end
        repeat (2) begin plan_p.push_back(50); plan_h.push_back(25); end
        test_pulse_train("switch");

        repeat (12) begin
            p = int'($urandom_range(300, 2));
            plan_p.push_back(p);
            plan_h.push_back(int'($urandom_range(p - 1, 1)));
        end
        test_pulse_train("random");

        plan_p.push_back(MAX);
        plan_h.push_back(int'($urandom_range(MAX - 1, 1)));
        test_pulse_train("max_period");

        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
